// File: rtl/obstacle_scroller.sv
// Scroll controller for the five pipe/coin slots: moves pipe X edges left each
// frame tick, recycles the leftmost slot to the right and rotates the ROM indices.

module obstacle_slot #(
    parameter int X_INIT  = 400,
    parameter int SPACING = 0,
    parameter int STEP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       advance,
    input  logic       recycle,
    input  logic [9:0] src,
    output logic [9:0] x
);
    localparam logic [9:0] INIT_W = 10'(X_INIT);
    localparam logic [9:0] SPC_W  = 10'(SPACING);
    localparam logic [9:0] STEP_W = 10'(STEP);

    // On recycle the slot takes its right neighbour's edge; the last slot
    // instead jumps one spacing past its own position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       x <= INIT_W;
        else if (restart) x <= INIT_W;
        else if (advance) x <= (recycle ? src + SPC_W : x) - STEP_W;
    end
endmodule

module obstacle_scroller #(
    parameter int X_START      = 400,
    parameter int PIPE_SPACING = 150,
    parameter int STEP         = 2,
    parameter int PIPE_WIDTH   = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       run,
    input  logic       restart,
    input  logic [4:0] coin_hit,
    output logic [2:0] I,
    output logic [2:0] IC,
    output logic [9:0] XEdge0,
    output logic [9:0] XEdge1,
    output logic [9:0] XEdge2,
    output logic [9:0] XEdge3,
    output logic [9:0] XEdge4,
    output logic [4:0] coin_vis,
    output logic       pipe_passed,
    output logic [7:0] pass_count
);
    localparam int         NUM_SLOTS = 5;
    localparam logic [9:0] STEP_W    = 10'(STEP);

    if (STEP < 1 || PIPE_WIDTH < 1 || X_START + 4 * PIPE_SPACING > 1023) begin : g_bad_params
        $error("obstacle_scroller: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, SCROLL, HALT} state_t;

    state_t                         state, state_nxt;
    logic [NUM_SLOTS-1:0][9:0]      xedge;
    logic                           advance, recycle, in_scroll;
    logic [4:0]                     coin_clr;

    function automatic logic [2:0] rot_next(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    assign in_scroll = (state == SCROLL);
    assign advance   = in_scroll && tick;
    assign recycle   = advance && (xedge[0] <= STEP_W);
    // Hits clear pre-shift slots, so the shift below moves them with their pipe.
    assign coin_clr  = in_scroll ? (coin_vis & ~coin_hit) : coin_vis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run)  state_nxt = SCROLL;
            SCROLL:  if (!run) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        if (restart) state_nxt = IDLE;
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        logic [9:0] src;
        if (k == NUM_SLOTS - 1) begin : g_last
            assign src = xedge[k];
        end else begin : g_mid
            assign src = xedge[k+1];
        end
        obstacle_slot #(
            .X_INIT  (X_START + k * PIPE_SPACING),
            .SPACING ((k == NUM_SLOTS - 1) ? PIPE_SPACING : 0),
            .STEP    (STEP)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .restart (restart),
            .advance (advance),
            .recycle (recycle),
            .src     (src),
            .x       (xedge[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            I           <= 3'd0;
            IC          <= 3'd0;
            coin_vis    <= 5'b11111;
            pipe_passed <= 1'b0;
            pass_count  <= 8'd0;
        end else if (restart) begin
            I           <= 3'd0;
            IC          <= 3'd0;
            coin_vis    <= 5'b11111;
            pipe_passed <= 1'b0;
            pass_count  <= 8'd0;
        end else begin
            pipe_passed <= recycle;
            coin_vis    <= recycle ? {1'b1, coin_clr[4:1]} : coin_clr;
            if (recycle) begin
                I  <= rot_next(I);
                IC <= rot_next(IC);
                if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
            end
        end
    end

    assign XEdge0 = xedge[0];
    assign XEdge1 = xedge[1];
    assign XEdge2 = xedge[2];
    assign XEdge3 = xedge[3];
    assign XEdge4 = xedge[4];
endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed-vector bench for obstacle_scroller: table of tick bursts with
// hand-computed positions, plus saturation and async-reset sequences.

module tb_obstacle_scroller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, run = 1'b0, restart = 1'b0;
    logic [4:0] coin_hit = 5'd0;
    logic [2:0] I, IC;
    logic [9:0] XEdge0, XEdge1, XEdge2, XEdge3, XEdge4;
    logic [4:0] coin_vis;
    logic       pipe_passed;
    logic [7:0] pass_count;

    int checks = 0;
    int errors = 0;

    obstacle_scroller dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .restart(restart),
        .coin_hit(coin_hit), .I(I), .IC(IC),
        .XEdge0(XEdge0), .XEdge1(XEdge1), .XEdge2(XEdge2), .XEdge3(XEdge3), .XEdge4(XEdge4),
        .coin_vis(coin_vis), .pipe_passed(pipe_passed), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ntick;
        logic       run;
        logic       restart;
        logic [4:0] coin;
        logic [9:0] x0, x1, x4;
        logic [2:0] i;
        logic [4:0] cv;
        logic [7:0] pc;
        logic       pp;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ntick=0 means one idle cycle; coin_hit/restart go out on the last cycle only.
    task automatic apply(input vec_t v);
        int n;
        n = (v.ntick == 0) ? 1 : v.ntick;
        for (int c = 0; c < n; c++) begin
            run      = v.run;
            tick     = (v.ntick != 0);
            coin_hit = (c == n - 1) ? v.coin : 5'd0;
            restart  = (c == n - 1) ? v.restart : 1'b0;
            @(posedge clk); #1;
        end
        tick = 1'b0; coin_hit = 5'd0; restart = 1'b0;
    endtask

    initial begin
        //            ntick run rst coin     x0   x1   x4    i  cv         pc  pp
        tv.push_back('{0,   0, 0, 5'b00000, 400, 550, 1000, 0, 5'b11111, 0,  0}); // reset values
        tv.push_back('{1,   1, 0, 5'b00000, 400, 550, 1000, 0, 5'b11111, 0,  0}); // tick in IDLE
        tv.push_back('{199, 1, 0, 5'b00000, 2,   152, 602,  0, 5'b11111, 0,  0});
        tv.push_back('{1,   1, 0, 5'b00000, 150, 300, 750,  1, 5'b11111, 1,  1}); // first recycle
        tv.push_back('{0,   1, 0, 5'b00000, 150, 300, 750,  1, 5'b11111, 1,  0}); // pulse drops
        tv.push_back('{0,   1, 0, 5'b00100, 150, 300, 750,  1, 5'b11011, 1,  0}); // hit, no tick
        tv.push_back('{74,  1, 0, 5'b00000, 2,   152, 602,  1, 5'b11011, 1,  0});
        tv.push_back('{1,   1, 0, 5'b00100, 150, 300, 750,  2, 5'b11101, 2,  1}); // hit with recycle
        tv.push_back('{75,  1, 0, 5'b00000, 150, 300, 750,  3, 5'b11110, 3,  1});
        tv.push_back('{75,  1, 0, 5'b00001, 150, 300, 750,  4, 5'b11111, 4,  1}); // slot0 hit discarded
        tv.push_back('{75,  1, 0, 5'b00000, 150, 300, 750,  0, 5'b11111, 5,  1}); // I wraps
        tv.push_back('{10,  1, 0, 5'b00000, 130, 280, 730,  0, 5'b11111, 5,  0});
        tv.push_back('{1,   0, 0, 5'b00000, 128, 278, 728,  0, 5'b11111, 5,  0}); // run drop with tick
        tv.push_back('{10,  0, 0, 5'b11111, 128, 278, 728,  0, 5'b11111, 5,  0}); // HALT frozen
        tv.push_back('{5,   1, 0, 5'b00000, 128, 278, 728,  0, 5'b11111, 5,  0}); // run can't leave HALT
        tv.push_back('{1,   0, 1, 5'b00000, 400, 550, 1000, 0, 5'b11111, 0,  0}); // restart
        tv.push_back('{5,   0, 0, 5'b00100, 400, 550, 1000, 0, 5'b11111, 0,  0}); // IDLE ignores
        tv.push_back('{1,   1, 0, 5'b00000, 400, 550, 1000, 0, 5'b11111, 0,  0});
        tv.push_back('{3,   1, 0, 5'b00000, 394, 544, 994,  0, 5'b11111, 0,  0});
        tv.push_back('{1,   1, 1, 5'b11111, 400, 550, 1000, 0, 5'b11111, 0,  0}); // restart beats tick

        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tv[n]) begin
            apply(tv[n]);
            chk($sformatf("v%0d XEdge0", n), 32'(XEdge0), 32'(tv[n].x0));
            chk($sformatf("v%0d XEdge1", n), 32'(XEdge1), 32'(tv[n].x1));
            chk($sformatf("v%0d XEdge4", n), 32'(XEdge4), 32'(tv[n].x4));
            chk($sformatf("v%0d I", n), 32'(I), 32'(tv[n].i));
            chk($sformatf("v%0d IC", n), 32'(IC), 32'(tv[n].i));
            chk($sformatf("v%0d coin_vis", n), 32'(coin_vis), 32'(tv[n].cv));
            chk($sformatf("v%0d pass_count", n), 32'(pass_count), 32'(tv[n].pc));
            chk($sformatf("v%0d pipe_passed", n), 32'(pipe_passed), 32'(tv[n].pp));
        end

        // 256 recycles from initial values: pass_count saturates, I = 256 mod 5.
        run = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 200 + 255 * 75; c++) begin
            tick = 1'b1;
            @(posedge clk); #1;
            if (I > 3'd4 || XEdge0 < 10'd1 || XEdge4 < XEdge0) begin
                chk("range I/X", {19'd0, I, XEdge0}, 32'hFFFF_FFFF);
            end
        end
        tick = 1'b0;
        @(posedge clk); #1;
        chk("sat pass_count", 32'(pass_count), 32'd255);
        chk("sat I", 32'(I), 32'd1);
        chk("sat IC", 32'(IC), 32'd1);
        chk("sat XEdge0", 32'(XEdge0), 32'd150);
        chk("sat XEdge4", 32'(XEdge4), 32'd750);

        tick = 1'b1;
        repeat (2) @(posedge clk);
        #1 tick = 1'b0;
        chk("pre-rst XEdge0", 32'(XEdge0), 32'd146);

        // Asynchronous reset mid-cycle, checked before any further clock edge.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst XEdge0", 32'(XEdge0), 32'd400);
        chk("arst XEdge2", 32'(XEdge2), 32'd700);
        chk("arst XEdge3", 32'(XEdge3), 32'd850);
        chk("arst XEdge4", 32'(XEdge4), 32'd1000);
        chk("arst I", 32'(I), 32'd0);
        chk("arst IC", 32'(IC), 32'd0);
        chk("arst pass_count", 32'(pass_count), 32'd0);
        chk("arst coin_vis", 32'(coin_vis), 32'd31);

        // After reset the block idles until run rises, even with ticks.
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b0; tick = 1'b1;
        repeat (3) @(posedge clk);
        #1 tick = 1'b0;
        chk("post-rst idle XEdge0", 32'(XEdge0), 32'd400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Sequential scroll controller for the five pipe/coin obstacles; sits directly upstream of the obstacle height ROM.
- Each frame tick it moves five pipe X edges left. When the leftmost pipe leaves the screen it recycles that slot to the far right.
- On recycle it advances the rotation indices I and IC so the height ROM's per-slot Y edges and coin Y values rotate in step.
- Also tracks per-slot coin visibility and a passed-pipe counter for the scoring/VGA logic.

Parameters:
- X_START, 400: initial right-edge X of slot 0 (pixels).
- PIPE_SPACING, 150: X distance between consecutive slots. X_START + 4*PIPE_SPACING must be ≤ 1023.
- STEP, 2: pixels moved per tick; must be ≥ 1.
- PIPE_WIDTH, 40: pipe width. Informational only; pipe occupies [X−PIPE_WIDTH, X).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle frame strobe
- run  in  1  game active level
- restart  in  1  synchronous one-cycle restart strobe
- coin_hit  in  5  one-hot (per slot) coin collected strobe
- I  out  3  pipe rotation index to height ROM, 0..4
- IC  out  3  coin rotation index to height ROM, 0..4
- XEdge0..XEdge4  out  10 each  right-edge X of slot 0..4
- coin_vis  out  5  per-slot coin visible flags
- pipe_passed  out  1  one-cycle pulse on recycle
- pass_count  out  8  saturating count of recycled pipes

Behaviour:
- Reset (rst_n=0, async) and restart both load initial values:
  - XEdgek = X_START + k*PIPE_SPACING
  - I=0, IC=0
  - coin_vis=5'b11111
  - pipe_passed=0, pass_count=0
  - state=IDLE
- State machine:
  - IDLE: positions held. Goes to SCROLL on run=1.
  - SCROLL: acts on each tick. Goes to HALT on run=0.
  - HALT: everything frozen; tick and coin_hit ignored; leaves only via restart or reset.
  - restart in any state → IDLE with initial values, next edge. restart has priority over tick, coin_hit and run.
- Tick in SCROLL, no recycle (XEdge0 > STEP): every XEdgek −= STEP. Visible one cycle after the tick.
- Tick in SCROLL, recycle (XEdge0 ≤ STEP):
  - Shift down: XEdgek ← old XEdge(k+1) − STEP for k=0..3.
  - XEdge4 ← old XEdge4 − STEP + PIPE_SPACING.
  - coin_vis ← {1'b1, coin_vis[4:1]}.
  - I ← (I==4) ? 0 : I+1; IC advances identically.
  - pipe_passed=1 for exactly one cycle.
  - pass_count +1, saturating at 255.
- No X value ever underflows below 0 or exceeds 1023. Arithmetic is 10-bit unsigned.
- coin_hit in SCROLL (with or without tick): clears coin_vis[k] for each set bit k.
  - Same cycle as a recycle: the clear applies to pre-shift slots, then the shift happens. A hit on slot 0 is therefore discarded; a hit on slot k lands on k−1.
- coin_hit in IDLE/HALT is ignored.
- I/IC never take values 5..7.
- tick without run, or in IDLE: no motion.
- run dropping in the same cycle as a tick: the tick is still applied, then state goes to HALT.

Test Plan:
- Reset: after rst_n release → XEdge0..4=400,550,700,850,1000; I=IC=0; coin_vis=11111; pass_count=0.
- run=1 and 199 ticks → XEdge0=2, XEdge4=602, I=0. Tick 200 → XEdge0=150, XEdge4=750, I=IC=1, pipe_passed high exactly one cycle, pass_count=1.
- Five consecutive recycles from reset → I sequence 1,2,3,4,0; pass_count=5; X values always within 1..1023.
- coin_hit=00100 with no tick → coin_vis=11011. Next coin_hit=00100 arriving with a recycling tick → coin_vis=11101, with bit 4 set.
- run→0 mid-scroll, then 10 ticks and coin_hit=11111 → all outputs unchanged. restart → initial values; ticks ignored until run=1.
- rst_n asserted mid-scroll, asynchronously between clock edges → outputs go to reset values immediately without a clock edge. Restart and tick in the same cycle → initial values, no motion applied.
